// File: rtl/lcd_frame_source.sv
// rtl/lcd_frame_source.sv - ST7789 frame byte source: window commands, then RGB565 test-pattern pixels.
// Valid/ready byte stream with a per-byte register-select (dc) flag.
module lcd_frame_source #(
  parameter int WIDTH    = 240,
  parameter int HEIGHT   = 135,
  parameter int X_OFFSET = 40,
  parameter int Y_OFFSET = 53
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [15:0] color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_dc,
  output logic        busy,
  output logic        frame_done
);

  localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BAR_W = (WIDTH >= 8) ? WIDTH / 8 : 1;

  localparam logic [15:0] XS = 16'(X_OFFSET);
  localparam logic [15:0] XE = 16'(X_OFFSET + WIDTH - 1);
  localparam logic [15:0] YS = 16'(Y_OFFSET);
  localparam logic [15:0] YE = 16'(Y_OFFSET + HEIGHT - 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, CMD, PIXEL_HI, PIXEL_LO} state_t;

  state_t        state, state_n;
  logic [3:0]    cmd_idx, cmd_n;
  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [1:0]    mode_q;
  logic [15:0]   color_q, pixel_q, pixel_n;
  logic [8:0]    cmd_byte;
  logic          xfer, last_px, done_n;
  int            bar;

  assign xfer    = out_valid & out_ready;
  assign last_px = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cmd_idx    <= 4'd0;
      x          <= '0;
      y          <= '0;
      mode_q     <= 2'd0;
      color_q    <= 16'h0000;
      pixel_q    <= 16'h0000;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cmd_idx    <= cmd_n;
      x          <= x_n;
      y          <= y_n;
      pixel_q    <= pixel_n;
      frame_done <= done_n;
      if (state == IDLE && start) begin
        mode_q  <= mode;
        color_q <= color;
      end
    end
  end

  always_comb begin
    state_n = state;
    cmd_n   = cmd_idx;
    x_n     = x;
    y_n     = y;
    done_n  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_n = CMD;
        cmd_n   = 4'd0;
        x_n     = '0;
        y_n     = '0;
      end
      CMD: if (xfer) begin
        cmd_n = cmd_idx + 4'd1;
        if (cmd_idx == 4'd10) state_n = PIXEL_HI;
      end
      PIXEL_HI: if (xfer) state_n = PIXEL_LO;
      PIXEL_LO: if (xfer) begin
        if (x == X_LAST) begin
          x_n = '0;
          y_n = (y == Y_LAST) ? '0 : y + 1'b1;
        end else begin
          x_n = x + 1'b1;
        end
        if (last_px) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = PIXEL_HI;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Pixel is computed from the coordinates the counters will hold next cycle,
  // so it is already registered when PIXEL_HI presents its high byte.
  always_comb begin
    pixel_n = color_q;
    bar     = int'(x_n) / BAR_W;
    case (mode_q)
      2'd0: pixel_n = color_q;
      2'd1: begin
        if (bar >= 7) pixel_n = 16'h0000;
        else begin
          case (bar)
            0:       pixel_n = 16'hFFFF;
            1:       pixel_n = 16'hFFE0;
            2:       pixel_n = 16'h07FF;
            3:       pixel_n = 16'h07E0;
            4:       pixel_n = 16'hF81F;
            5:       pixel_n = 16'hF800;
            default: pixel_n = 16'h001F;
          endcase
        end
      end
      2'd2: pixel_n = (1'(x_n >> 3) ^ 1'(y_n >> 3)) ? ~color_q : color_q;
      default: pixel_n = {5'(x_n >> 3), 6'(y_n >> 2), 5'h00};
    endcase
  end

  always_comb begin
    case (cmd_idx)
      4'd0:    cmd_byte = {1'b0, 8'h2A};
      4'd1:    cmd_byte = {1'b1, XS[15:8]};
      4'd2:    cmd_byte = {1'b1, XS[7:0]};
      4'd3:    cmd_byte = {1'b1, XE[15:8]};
      4'd4:    cmd_byte = {1'b1, XE[7:0]};
      4'd5:    cmd_byte = {1'b0, 8'h2B};
      4'd6:    cmd_byte = {1'b1, YS[15:8]};
      4'd7:    cmd_byte = {1'b1, YS[7:0]};
      4'd8:    cmd_byte = {1'b1, YE[15:8]};
      4'd9:    cmd_byte = {1'b1, YE[7:0]};
      4'd10:   cmd_byte = {1'b0, 8'h2C};
      default: cmd_byte = 9'h000;
    endcase
  end

  always_comb begin
    out_valid = (state != IDLE);
    busy      = (state != IDLE);
    out_data  = 8'h00;
    out_dc    = 1'b0;
    case (state)
      CMD:      {out_dc, out_data} = cmd_byte;
      PIXEL_HI: {out_dc, out_data} = {1'b1, pixel_q[15:8]};
      PIXEL_LO: {out_dc, out_data} = {1'b1, pixel_q[7:0]};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_source.sv
// tb/tb_lcd_frame_source.sv - self-checking bench for lcd_frame_source.
// Three sizes: 4x2 (offsets 0), 24x20 (offsets 5/7), default 240x135.
module tb_lcd_frame_source;

  localparam int PW  [3] = '{4, 24, 240};
  localparam int PH  [3] = '{2, 20, 135};
  localparam int PXO [3] = '{0, 5, 40};
  localparam int PYO [3] = '{0, 7, 53};

  logic        clk = 1'b0;
  logic        reset;
  logic        start      [3];
  logic [1:0]  mode       [3];
  logic [15:0] color      [3];
  logic        out_ready  [3];
  logic        out_valid  [3];
  logic [7:0]  out_data   [3];
  logic        out_dc     [3];
  logic        busy       [3];
  logic        frame_done [3];

  int total = 0;
  int bad   = 0;
  logic [7:0] hdr_cap [11];

  always #5 clk = ~clk;

  lcd_frame_source #(.WIDTH(4), .HEIGHT(2), .X_OFFSET(0), .Y_OFFSET(0)) u_small (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]), .color(color[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_dc(out_dc[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  lcd_frame_source #(.WIDTH(24), .HEIGHT(20), .X_OFFSET(5), .Y_OFFSET(7)) u_mid (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]), .color(color[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_dc(out_dc[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  lcd_frame_source u_dflt (
    .clk(clk), .reset(reset), .start(start[2]), .mode(mode[2]), .color(color[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_dc(out_dc[2]), .busy(busy[2]), .frame_done(frame_done[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic int model_pix(input int i, input int x, input int y, input int m, input int c);
    int bars [8] = '{'hFFFF, 'hFFE0, 'h07FF, 'h07E0, 'hF81F, 'hF800, 'h001F, 'h0000};
    int idx;
    case (m)
      0: return c;
      1: begin
        idx = x / (PW[i] / 8);
        if (idx > 7) idx = 7;
        return bars[idx];
      end
      2: return (((x / 8) % 2) != ((y / 8) % 2)) ? (~c & 'hFFFF) : c;
      default: return ((x / 8) % 32) * 2048 + ((y / 4) % 64) * 32;
    endcase
  endfunction

  // Expected {dc, data} of transfer number k in a frame.
  function automatic logic [8:0] model_byte(input int i, input int k, input int m, input int c);
    logic [15:0] xs, xe, ys, ye, pix;
    int p, x, y;
    xs = 16'(PXO[i]);
    xe = 16'(PXO[i] + PW[i] - 1);
    ys = 16'(PYO[i]);
    ye = 16'(PYO[i] + PH[i] - 1);
    case (k)
      0:  return {1'b0, 8'h2A};
      1:  return {1'b1, xs[15:8]};
      2:  return {1'b1, xs[7:0]};
      3:  return {1'b1, xe[15:8]};
      4:  return {1'b1, xe[7:0]};
      5:  return {1'b0, 8'h2B};
      6:  return {1'b1, ys[15:8]};
      7:  return {1'b1, ys[7:0]};
      8:  return {1'b1, ye[15:8]};
      9:  return {1'b1, ye[7:0]};
      10: return {1'b0, 8'h2C};
      default: begin
        p   = (k - 11) / 2;
        x   = p % PW[i];
        y   = p / PW[i];
        pix = 16'(model_pix(i, x, y, m, c));
        return ((k - 11) % 2 == 0) ? {1'b1, pix[15:8]} : {1'b1, pix[7:0]};
      end
    endcase
  endfunction

  // Starts a frame, checks every transferred byte and every stall against the model,
  // optionally glitches start mid-frame, aborts by reset at abort_at, or restarts at M+1.
  task automatic run_frame(input int i, input int m, input int c, input int rdy,
                           input int abort_at, input int glitch_at, input int tx, input int ty,
                           input bit chain, output int pix);
    int n, k, cyc, errs, dones, thi;
    bit stall, glitched;
    logic [8:0] held, got;
    n = 11 + 2 * PW[i] * PH[i];
    thi = 11 + 2 * (ty * PW[i] + tx);
    pix = 0; k = 0; cyc = 0; errs = 0; dones = 0; stall = 0; glitched = 0; held = '0;
    @(negedge clk);
    start[i] = 1'b1; mode[i] = 2'(m); color[i] = 16'(c); out_ready[i] = 1'b0;
    @(negedge clk);
    start[i] = 1'b0;
    check("start_latency", {busy[i], out_valid[i], out_dc[i], out_data[i]}, {3'b110, 8'h2A});
    while (k < n && cyc < 4 * n + 100) begin
      if (abort_at >= 0 && k == abort_at) break;
      start[i] = 1'b0;
      if (k == glitch_at && !glitched) begin
        start[i] = 1'b1; mode[i] = 2'd1; color[i] = 16'h0000; glitched = 1;
      end
      out_ready[i] = ($urandom_range(99) < rdy);
      got = {out_dc[i], out_data[i]};
      if (frame_done[i]) dones++;
      if (!out_valid[i]) errs++;
      if (stall && got !== held) errs++;
      stall = 0;
      if (out_ready[i]) begin
        if (got !== model_byte(i, k, m, c)) errs++;
        if (k < 11) hdr_cap[k] = out_data[i];
        if (k == thi) pix = pix | (int'(out_data[i]) << 8);
        if (k == thi + 1) pix = pix | int'(out_data[i]);
        k++;
      end else begin
        stall = 1; held = got;
      end
      @(negedge clk);
      cyc++;
    end
    start[i] = 1'b0;
    out_ready[i] = 1'b0;
    check("stream_errors", errs, 0);
    check("no_early_done", dones, 0);
    if (abort_at >= 0) begin
      reset = 1'b1;
      #1;
      check("abort_idle", {out_valid[i], out_data[i], out_dc[i], busy[i], frame_done[i]}, 0);
      @(negedge clk);
      reset = 1'b0;
    end else begin
      check("frame_length", k, n);
      check("frame_end", {frame_done[i], busy[i], out_valid[i]}, 3'b100);
      if (chain) start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      check("done_pulse_width", frame_done[i], 0);
      if (chain) begin
        check("restart_m1", {busy[i], out_valid[i], out_data[i]}, {2'b11, 8'h2A});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
  endtask

  typedef struct {
    int inst; int m; int c; int x; int y; int exp;
  } vec_t;

  initial begin
    vec_t vecs [10];
    logic [7:0] hdr_small [11];
    logic [7:0] hdr_dflt  [11];
    int pix, rm, rc;

    vecs[0] = '{2, 1, 'h0000,   0,   0, 'hFFFF};
    vecs[1] = '{2, 1, 'h0000,  30,   0, 'hFFE0};
    vecs[2] = '{2, 1, 'h0000, 239,   0, 'h0000};
    vecs[3] = '{2, 2, 'h1234,   0,   0, 'h1234};
    vecs[4] = '{2, 2, 'h1234,   8,   0, 'hEDCB};
    vecs[5] = '{2, 2, 'h1234,   8,   8, 'h1234};
    vecs[6] = '{0, 0, 'hF800,   3,   1, 'hF800};
    vecs[7] = '{1, 1, 'h0000,   9,   0, 'h07E0};
    vecs[8] = '{1, 1, 'h0000,  23,   5, 'h0000};
    vecs[9] = '{2, 3, 'h0000, 200, 100, 'hCB20};
    hdr_small = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
    hdr_dflt  = '{8'h2A, 8'h00, 8'h28, 8'h01, 8'h17, 8'h2B, 8'h00, 8'h35, 8'h00, 8'hBB, 8'h2C};

    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; mode[i] = 2'd0; color[i] = 16'h0; out_ready[i] = 1'b1;
    end
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) start[i] = t[0];
    end
    for (int i = 0; i < 3; i++)
      check("reset_values", {out_valid[i], out_data[i], out_dc[i], busy[i], frame_done[i]}, 0);
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("idle_ready_no_effect", {out_valid[i], busy[i]}, 0);
      out_ready[i] = 1'b0;
    end

    // Small solid frame, full ready, then restart accepted right after frame end.
    run_frame(0, 0, 'hF800, 100, -1, -1, 0, 0, 1'b1, pix);
    for (int j = 0; j < 11; j++) check("small_header", hdr_cap[j], hdr_small[j]);
    // Same frame under random backpressure.
    run_frame(0, 0, 'hF800, 50, -1, -1, 0, 0, 1'b0, pix);
    // Start with mode 1 mid-frame must be ignored.
    run_frame(0, 0, 'hF800, 100, -1, 13, 0, 0, 1'b0, pix);
    run_frame(1, 2, 'h5A5A, 60, -1, 200, 0, 0, 1'b0, pix);

    foreach (vecs[v]) begin
      run_frame(vecs[v].inst, vecs[v].m, vecs[v].c, 100,
                11 + 2 * (vecs[v].y * PW[vecs[v].inst] + vecs[v].x) + 2, -1,
                vecs[v].x, vecs[v].y, 1'b0, pix);
      check($sformatf("pixel_vec%0d", v), pix, vecs[v].exp);
      if (v == 0)
        for (int j = 0; j < 11; j++) check("default_header", hdr_cap[j], hdr_dflt[j]);
    end

    for (int f = 0; f < 3; f++) begin
      rm = int'($urandom_range(3));
      rc = int'($urandom_range(16'hFFFF));
      run_frame(1, rm, rc, 50, -1, -1, 0, 0, 1'b0, pix);
    end

    // Reset at transfer 100, then a complete frame must follow.
    run_frame(1, 3, 'h0, 100, 100, -1, 0, 0, 1'b0, pix);
    check("post_abort_no_done", frame_done[1], 0);
    run_frame(1, 1, 'h0, 70, -1, -1, 0, 0, 1'b0, pix);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
